// File: rtl/pipeline_flush_ctrl.sv
// End-of-image flush sequencer: waits for the pipeline to drain, flushes each
// stage in order (bounded by a per-stage timeout), then soft-resets the pipeline.
module pipeline_flush_ctrl #(
    parameter int NUM_FLUSH    = 2,
    parameter int DRAIN_CYCLES = 4,
    parameter int FLUSH_CYCLES = 4,
    parameter int TIMEOUT      = 64
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 done_image,
    input  logic [NUM_FLUSH-1:0] stage_busy,
    output logic [NUM_FLUSH-1:0] flush,
    output logic                 rst_pipeline,
    output logic                 done_flush,
    output logic                 busy,
    output logic                 timeout_err
);

    // Counter must also hold the drain count in case DRAIN_CYCLES exceeds TIMEOUT.
    localparam int CNT_MAX = (DRAIN_CYCLES > TIMEOUT) ? DRAIN_CYCLES : TIMEOUT;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int IDX_W   = (NUM_FLUSH > 1) ? $clog2(NUM_FLUSH) : 1;

    localparam logic [CNT_W-1:0]     DRAIN_LAST = CNT_W'(DRAIN_CYCLES - 1);
    localparam logic [CNT_W-1:0]     FLUSH_MIN  = CNT_W'(FLUSH_CYCLES - 1);
    localparam logic [CNT_W-1:0]     TO_LAST    = CNT_W'(TIMEOUT - 1);
    localparam logic [IDX_W-1:0]     IDX_LAST   = IDX_W'(NUM_FLUSH - 1);
    localparam logic [NUM_FLUSH-1:0] FLUSH_ONE  = NUM_FLUSH'(1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRAIN = 2'd1,
        ST_FLUSH = 2'd2,
        ST_RESET = 2'd3
    } state_t;

    state_t               state_q, state_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 terr_q, terr_d;
    logic [NUM_FLUSH-1:0] flush_q, flush_d;
    logic                 rst_pipeline_q;
    logic                 done_flush_q;
    logic                 busy_q;
    logic                 sel_busy_s;
    logic                 exit_s;

    // Next-state, stage index, cycle counter and timeout flag.
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        cnt_d      = cnt_q;
        terr_d     = terr_q;
        sel_busy_s = stage_busy[idx_q];
        exit_s     = ((cnt_q >= FLUSH_MIN) && !sel_busy_s) || (cnt_q == TO_LAST);
        case (state_q)
            ST_IDLE: begin
                if (done_image) begin
                    state_d = ST_DRAIN;
                    cnt_d   = '0;
                    idx_d   = '0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_DRAIN: begin
                if (cnt_q == DRAIN_LAST) begin
                    state_d = ST_FLUSH;
                    cnt_d   = '0;
                    idx_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_FLUSH: begin
                if (exit_s) begin
                    cnt_d = '0;
                    if ((cnt_q == TO_LAST) && sel_busy_s) begin
                        terr_d = 1'b1;
                    end else begin
                        terr_d = terr_q;
                    end
                    if (idx_q == IDX_LAST) begin
                        state_d = ST_RESET;
                        idx_d   = '0;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_RESET: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
                idx_d   = '0;
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
                idx_d   = '0;
            end
        endcase
    end

    // Flush pulse is decoded from the next state so the output can be registered.
    always_comb begin
        flush_d = '0;
        if ((state_d == ST_FLUSH) && (cnt_d == '0)) begin
            flush_d = FLUSH_ONE << idx_d;
        end else begin
            flush_d = '0;
        end
    end

    // State and registered outputs with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q        <= ST_IDLE;
            idx_q          <= '0;
            cnt_q          <= '0;
            terr_q         <= 1'b0;
            flush_q        <= '0;
            rst_pipeline_q <= 1'b0;
            done_flush_q   <= 1'b0;
            busy_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            idx_q          <= idx_d;
            cnt_q          <= cnt_d;
            terr_q         <= terr_d;
            flush_q        <= flush_d;
            rst_pipeline_q <= (state_d == ST_RESET);
            done_flush_q   <= (state_q == ST_RESET);
            busy_q         <= (state_d != ST_IDLE);
        end
    end

    assign flush        = flush_q;
    assign rst_pipeline = rst_pipeline_q;
    assign done_flush   = done_flush_q;
    assign busy         = busy_q;
    assign timeout_err  = terr_q;

endmodule

// File: doc/pipeline_flush_ctrl.md
PIPELINE_FLUSH_CTRL -- requirements
Module: pipeline_flush_ctrl

Interface
REQ-001 SHALL have parameter NUM_FLUSH, default 2: number of flushable stages, legal range 1..8; index 0 is flushed first.
REQ-002 SHALL have parameter DRAIN_CYCLES, default 4: cycles waited after done_image before the first flush, >=1.
REQ-003 SHALL have parameter FLUSH_CYCLES, default 4: minimum cycles spent per flush stage, >=1.
REQ-004 SHALL have parameter TIMEOUT, default 64: maximum cycles spent per flush stage, > FLUSH_CYCLES.
REQ-005 clk  input  1  single clock; all logic on posedge clk.
REQ-006 rst_n  input  1  reset, synchronous, active-low.
REQ-007 done_image  input  1  single-cycle pulse: last block of the image has entered the pipeline.
REQ-008 stage_busy  input  NUM_FLUSH  per-stage "still emitting flushed data" indication.
REQ-009 flush  output  NUM_FLUSH  one-cycle flush pulse per stage.
REQ-010 rst_pipeline  output  1  one-cycle pipeline soft-reset pulse.
REQ-011 done_flush  output  1  one-cycle pulse: flush sequence complete.
REQ-012 busy  output  1  high while a sequence is in progress.
REQ-013 timeout_err  output  1  sticky: some stage's busy never dropped within TIMEOUT.

Function
REQ-014 SHALL implement states IDLE, DRAIN, FLUSH, RESET, plus a stage index idx (0..NUM_FLUSH-1) and a cycle counter cnt of width $clog2(TIMEOUT+1).
REQ-015 IDLE: done_image=1 -> DRAIN with cnt=0; otherwise stay.
REQ-016 DRAIN: cnt increments each cycle; at cnt==DRAIN_CYCLES-1 -> FLUSH with idx=0, cnt=0.
REQ-017 FLUSH: flush[idx] SHALL be 1 only in the cycle cnt==0; all other flush bits 0.
REQ-018 FLUSH exit: (cnt>=FLUSH_CYCLES-1 and stage_busy[idx]==0) or cnt==TIMEOUT-1; on exit cnt=0 and idx increments, or -> RESET if idx==NUM_FLUSH-1.
REQ-019 Exit at cnt==TIMEOUT-1 with stage_busy[idx]==1 SHALL set timeout_err; the sequence continues normally.
REQ-020 stage_busy SHALL be ignored outside FLUSH and for stages other than idx.
REQ-021 RESET lasts exactly one cycle: rst_pipeline=1 (combinational from state), then -> IDLE.
REQ-022 done_flush SHALL be registered: 1 exactly in the cycle following RESET (first IDLE cycle), else 0.
REQ-023 busy = (state != IDLE).
REQ-024 done_image while busy=1 SHALL be ignored (not queued).
REQ-025 done_image in the cycle done_flush=1 SHALL start a new sequence (state is IDLE).
REQ-026 Latency with stage_busy=0, defaults, done_image sampled at cycle T: flush[0] at T+5, flush[1] at T+9, rst_pipeline at T+13, done_flush at T+14.
REQ-027 General no-busy latency: done_image -> rst_pipeline = DRAIN_CYCLES + NUM_FLUSH*FLUSH_CYCLES + 1 cycles.

Reset
REQ-028 rst_n=0 at a clock edge SHALL force state=IDLE, idx=0, cnt=0, flush=0, rst_pipeline=0, done_flush=0, busy=0, timeout_err=0, from any state.
REQ-029 Reset mid-sequence SHALL abort the sequence with no further flush, rst_pipeline or done_flush pulses.
REQ-030 timeout_err SHALL be cleared only by rst_n.

Verification
REQ-031 Defaults, stage_busy=0, done_image at T -> flush=01 at T+5, 10 at T+9, rst_pipeline at T+13, done_flush at T+14, busy high T+1..T+13.
REQ-032 stage_busy[0] held high until T+12 -> flush[1] at T+13 (exit once busy low), rst_pipeline at T+17, timeout_err=0.
REQ-033 stage_busy[1] stuck high -> FLUSH idx 1 exits after 64 cycles, timeout_err=1 and stays 1, rst_pipeline and done_flush still pulse once.
REQ-034 Second done_image at T+3 -> ignored; exactly one done_flush pulse at T+14.
REQ-035 rst_n=0 at T+7 -> all outputs 0 next cycle, no flush[1]/done_flush afterwards; a new done_image then produces a full sequence.
REQ-036 NUM_FLUSH=3, DRAIN_CYCLES=1, FLUSH_CYCLES=1 -> flush bits 001,010,100 at T+2,T+3,T+4; rst_pipeline at T+5; done_flush at T+6.
